// File: rtl/var7_multi_search.sv
// rtl/var7_multi_search.sv - sequential 7-item three-constraint knapsack solver
module var7_multi_search #(
  parameter int unsigned MIN_VALUE  = 58,
  parameter int unsigned MAX_WEIGHT = 60,
  parameter int unsigned MAX_VOLUME = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       found_o,
  output logic [6:0] best_sel_o,
  output logic [9:0] best_value_o,
  output logic [9:0] best_weight_o,
  output logic [9:0] best_volume_o,
  output logic [7:0] valid_count_o
);

  // Item table, index 0 = A ... index 6 = G
  localparam logic [9:0] ITEM_VAL [7] = '{10'd4,  10'd8,  10'd0,  10'd20, 10'd10, 10'd12, 10'd18};
  localparam logic [9:0] ITEM_WGT [7] = '{10'd28, 10'd8,  10'd27, 10'd18, 10'd27, 10'd28, 10'd6};
  localparam logic [9:0] ITEM_VOL [7] = '{10'd27, 10'd27, 10'd4,  10'd4,  10'd0,  10'd24, 10'd4};

  localparam logic [9:0] MIN_V = 10'(MIN_VALUE);
  localparam logic [9:0] MAX_W = 10'(MAX_WEIGHT);
  localparam logic [9:0] MAX_U = 10'(MAX_VOLUME);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_q;
  logic [6:0] cand_q;
  logic       busy_q, done_q, found_q;
  logic [6:0] best_sel_q;
  logic [9:0] best_value_q, best_weight_q, best_volume_q;
  logic [7:0] valid_count_q;

  logic [9:0] sum_value_d, sum_weight_d, sum_volume_d;
  logic       cand_valid_d, cand_better_d;

  // Totals and acceptance test for the candidate currently held in cand_q
  always_comb begin
    sum_value_d  = 10'd0;
    sum_weight_d = 10'd0;
    sum_volume_d = 10'd0;
    for (int i = 0; i < 7; i++) begin
      if (cand_q[i]) begin
        sum_value_d  = sum_value_d  + ITEM_VAL[i];
        sum_weight_d = sum_weight_d + ITEM_WGT[i];
        sum_volume_d = sum_volume_d + ITEM_VOL[i];
      end
    end
    cand_valid_d  = (sum_value_d >= MIN_V) && (sum_weight_d <= MAX_W) && (sum_volume_d <= MAX_U);
    // Strict comparisons keep the earlier (lower) code on a full tie
    cand_better_d = cand_valid_d &&
                    (!found_q ||
                     (sum_value_d > best_value_q) ||
                     ((sum_value_d == best_value_q) && (sum_weight_d < best_weight_q)));
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cand_q        <= 7'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      best_sel_q    <= 7'd0;
      best_value_q  <= 10'd0;
      best_weight_q <= 10'd0;
      best_volume_q <= 10'd0;
      valid_count_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q       <= SCAN;
            cand_q        <= 7'd0;
            busy_q        <= 1'b1;
            found_q       <= 1'b0;
            best_sel_q    <= 7'd0;
            best_value_q  <= 10'd0;
            best_weight_q <= 10'd0;
            best_volume_q <= 10'd0;
            valid_count_q <= 8'd0;
          end
        end
        SCAN: begin
          if (cand_valid_d) begin
            valid_count_q <= valid_count_q + 8'd1;
          end
          if (cand_better_d) begin
            found_q       <= 1'b1;
            best_sel_q    <= cand_q;
            best_value_q  <= sum_value_d;
            best_weight_q <= sum_weight_d;
            best_volume_q <= sum_volume_d;
          end
          cand_q <= cand_q + 7'd1;
          if (cand_q == 7'd127) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (ack_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign best_sel_o    = best_sel_q;
  assign best_value_o  = best_value_q;
  assign best_weight_o = best_weight_q;
  assign best_volume_o = best_volume_q;
  assign valid_count_o = valid_count_q;

endmodule

// File: tb/tb_var7_multi_search.sv
// tb/tb_var7_multi_search.sv - scoreboard bench for var7_multi_search
module tb_var7_multi_search;

  typedef struct packed {
    logic       found;
    logic [6:0] sel;
    logic [9:0] v;
    logic [9:0] w;
    logic [9:0] vol;
    logic [7:0] cnt;
  } res_t;

  typedef struct {
    res_t r0;
    res_t r1;
    res_t r2;
    int   cyc;
  } exp_t;

  // u0 default, u1 everything valid, u2 nothing valid
  localparam res_t EXP_DEF  = '{1'b1, 7'h6A, 10'd58, 10'd60,  10'd59, 8'd1};
  localparam res_t EXP_ALL  = '{1'b1, 7'h7B, 10'd72, 10'd115, 10'd86, 8'd128};
  localparam res_t EXP_NONE = '{1'b0, 7'h00, 10'd0,  10'd0,   10'd0,  8'd0};

  logic clk = 1'b0;
  logic rst, start, ack;
  logic       busy [3];
  logic       done [3];
  logic       fnd  [3];
  logic [6:0] sel  [3];
  logic [9:0] bv   [3];
  logic [9:0] bw   [3];
  logic [9:0] bvo  [3];
  logic [7:0] cnt  [3];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sbq [$];
  logic done_prev = 1'b0;
  res_t snap [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  var7_multi_search u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ack_i(ack),
    .busy_o(busy[0]), .done_o(done[0]), .found_o(fnd[0]), .best_sel_o(sel[0]),
    .best_value_o(bv[0]), .best_weight_o(bw[0]), .best_volume_o(bvo[0]), .valid_count_o(cnt[0])
  );

  var7_multi_search #(.MIN_VALUE(0), .MAX_WEIGHT(255), .MAX_VOLUME(255)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ack_i(ack),
    .busy_o(busy[1]), .done_o(done[1]), .found_o(fnd[1]), .best_sel_o(sel[1]),
    .best_value_o(bv[1]), .best_weight_o(bw[1]), .best_volume_o(bvo[1]), .valid_count_o(cnt[1])
  );

  var7_multi_search #(.MIN_VALUE(73)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ack_i(ack),
    .busy_o(busy[2]), .done_o(done[2]), .found_o(fnd[2]), .best_sel_o(sel[2]),
    .best_value_o(bv[2]), .best_weight_o(bw[2]), .best_volume_o(bvo[2]), .valid_count_o(cnt[2])
  );

  function automatic res_t get_act(input int i);
    res_t r;
    r = '{fnd[i], sel[i], bv[i], bw[i], bvo[i], cnt[i]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_res(input int i, input string tag, input res_t exp);
    res_t a;
    a = get_act(i);
    chk($sformatf("u%0d_%s_found", i, tag), 32'(a.found), 32'(exp.found));
    chk($sformatf("u%0d_%s_sel",   i, tag), 32'(a.sel),   32'(exp.sel));
    chk($sformatf("u%0d_%s_value", i, tag), 32'(a.v),     32'(exp.v));
    chk($sformatf("u%0d_%s_weight",i, tag), 32'(a.w),     32'(exp.w));
    chk($sformatf("u%0d_%s_volume",i, tag), 32'(a.vol),   32'(exp.vol));
    chk($sformatf("u%0d_%s_count", i, tag), 32'(a.cnt),   32'(exp.cnt));
  endtask

  // Monitor: on each rising done of u0, pop the expected result and compare all instances
  always @(negedge clk) begin
    if (!rst && done[0] && !done_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no scan outstanding", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.cyc));
        for (int i = 1; i < 3; i++) chk($sformatf("u%0d_done_sync", i), 32'(done[i]), 32'd1);
        chk_res(0, "result", e.r0);
        chk_res(1, "result", e.r1);
        chk_res(2, "result", e.r2);
      end
    end
    done_prev = done[0];
  end

  task automatic do_start(input bit push);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) sbq.push_back('{EXP_DEF, EXP_ALL, EXP_NONE, cyc + 128});
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      if (done[0]) break;
      @(posedge clk); #1;
    end
    chk("wait_done", 32'(done[0]), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("u%0d_rst_done", i), 32'(done[i]), 32'd0);
      chk_res(i, "rst", EXP_NONE);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // First scan, with a start pulse mid-scan that must be ignored
    do_start(1'b1);
    chk("busy_after_start", 32'(busy[0]), 32'd1);
    repeat (10) @(posedge clk); #1;
    do_start(1'b0);
    chk("busy_mid_scan", 32'(busy[0]), 32'd1);
    wait_done();
    chk("busy_at_done", 32'(busy[0]), 32'd0);

    // Hold ack low for 20 cycles; results must stay put, start in DONE ignored
    for (int i = 0; i < 3; i++) snap[i] = get_act(i);
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      @(posedge clk); #1;
      chk("done_held", 32'(done[0]), 32'd1);
      for (int i = 0; i < 3; i++)
        chk($sformatf("u%0d_stable", i), 32'(get_act(i) == snap[i]), 32'd1);
    end
    start = 1'b0;

    // start and ack together: only ack acts
    start = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    chk("done_after_ack", 32'(done[0]), 32'd0);
    chk("busy_after_ack", 32'(busy[0]), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("idle_no_scan", 32'(busy[0]), 32'd0);
    chk_res(0, "idle_hold", EXP_DEF);

    // Repeat scan must give the identical result
    do_start(1'b1);
    wait_done();
    do_ack();

    // Reset 50 cycles into a scan
    do_start(1'b0);
    repeat (49) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_midrst_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("u%0d_midrst_done", i), 32'(done[i]), 32'd0);
      chk_res(i, "midrst", EXP_NONE);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_start(1'b1);
    wait_done();
    do_ack();

    @(negedge clk); @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/var7_multi_search.md
# var7_multi_search

Sequential solver for the 7-item, three-constraint knapsack instance whose selections the combinational validity checkers accept. Rather than judging a given selection, it generates selections: it enumerates all 128 candidates, one per clock, and applies the value-floor, weight-cap and volume-cap test to each. It returns the best valid selection plus a count of valid selections. It sits between the test controller and the checker-side logic and produces reference answers for it.

## Interface
- MIN_VALUE, 58, minimum total value for a selection to be valid
- MAX_WEIGHT, 60, maximum total weight allowed
- MAX_VOLUME, 60, maximum total volume allowed
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a scan; accepted only in IDLE
- ack  input  1  consume the result; honoured only in DONE
- busy  output  1  high in SCAN
- done  output  1  high in DONE; result outputs are stable while high
- found  output  1  at least one valid selection exists
- best_sel  output  7  best selection; bit0=A, bit1=B, bit2=C, bit3=D, bit4=E, bit5=F, bit6=G
- best_value  output  10  total value of best_sel
- best_weight  output  10  total weight of best_sel
- best_volume  output  10  total volume of best_sel
- valid_count  output  8  number of valid selections (0..128)

## Operation
- Item table is fixed in RTL, listed as (value, weight, volume):
  - A 4/28/27, B 8/8/27, C 0/27/4, D 20/18/4, E 10/27/0, F 12/28/24, G 18/6/4.
- All sums are 10-bit unsigned with no wrap. Worst case is value 72, weight 142, volume 90.
- Comparisons are unsigned, with the parameters zero-extended to 10 bits.
- Valid means all three hold: value >= MIN_VALUE, weight <= MAX_WEIGHT, volume <= MAX_VOLUME.
- FSM has three states:
  - IDLE: on start, clear found, best_* and valid_count to 0, set the 7-bit candidate counter to 0, and go to SCAN.
  - SCAN: each cycle, evaluate the current candidate combinationally, update registers, and increment the candidate. After candidate 127 is evaluated, go to DONE.
  - DONE: hold all outputs. On ack, go to IDLE.
- A valid candidate increments valid_count. It replaces the best when any of these is true:
  - found=0,
  - its value > best_value,
  - its value == best_value and its weight < best_weight.
- On a full tie (equal value and equal weight) the earlier, lower code is kept.
- Result outputs keep their values in IDLE until the next accepted start clears them.
- start outside IDLE is ignored. ack outside DONE is ignored.
- If start and ack arrive together in DONE, only ack acts: the block returns to IDLE and start is not accepted that cycle.

## Timing
- Reset: state IDLE and candidate 0. busy, done, found, best_sel, best_value, best_weight, best_volume and valid_count are all 0. Reset takes priority over every input, including mid-scan.
- Start is accepted at edge T0, so busy=1 from T0.
- Candidate k is evaluated at edge T0+1+k.
- At edge T0+128, busy drops and done rises. Results are final in that same cycle.
- Scan latency is exactly 128 cycles, start edge to done.
- done stays high until the edge that samples ack=1; it is 0 in the following cycle.
- Earliest restart is one cycle after leaving DONE.
- Outputs are registered, with no combinational path from input to output.

## Test plan
- Default parameters:
  - Stimulus: pulse start, wait for done.
  - Required: done exactly 128 cycles after the start edge; found=1, valid_count=1, best_sel=0x6A (B,D,F,G), best_value=58, best_weight=60, best_volume=59.
- MIN_VALUE=0, MAX_WEIGHT=255, MAX_VOLUME=255:
  - Required: valid_count=128, best_sel=0x7B (all items except C; this checks the lower-weight tie-break), best_value=72, best_weight=115, best_volume=86.
- MIN_VALUE=73:
  - Required: found=0, valid_count=0, best_sel=0, best_value/best_weight/best_volume=0.
- Reset mid-scan:
  - Stimulus: assert rst 50 cycles after start.
  - Required: next cycle all outputs 0 and state IDLE; a fresh start then produces the default-case result.
- Handshake:
  - Stimulus: start pulses during SCAN and in DONE; hold ack low for 20 cycles after done; then raise start and ack together.
  - Required: start pulses are ignored; outputs are stable while done is held; the block returns to IDLE with no new scan; a later start gives an identical result.
